sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 25 ++
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/sync_fifo.sv | 107 ++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the sync_fifo slice.
package sync_fifo_pkg;

   localparam int MODE_STD  = 0;
   localparam int MODE_FWFT = 1;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) res++;
      return res;
   endfunction

   function automatic bit params_legal(input int data_w, input int depth,
                                       input int af_level, input int ae_level,
                                       input int fwft);
      bit ok;
      ok = (data_w >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0);
      ok = ok && (af_level >= 1) && (af_level <= depth - 1);
      ok = ok && (ae_level >= 1) && (ae_level <= depth - 1);
      ok = ok && ((fwft == MODE_STD) || (fwft == MODE_FWFT));
      return ok;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Unreset DATA_W x DEPTH register array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 256,
   localparam int AW     = clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Same-address read during a write returns the previously stored word.
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, status flags and read register around sync_fifo_mem.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int DEPTH    = 256,
   parameter  int AF_LEVEL = DEPTH - 4,
   parameter  int AE_LEVEL = 4,
   parameter  int FWFT     = MODE_STD,
   localparam int AW       = clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              w_en,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_en,
   output logic [DATA_W-1:0] r_data,
   output logic              w_full,
   output logic              r_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AW:0]       count,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_LEVEL);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   generate
      if (!params_legal(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_illegal
         $error("sync_fifo: illegal parameter set");
      end
   endgenerate

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] r_data_q, r_data_d;
   logic [DATA_W-1:0] mem_rdata;
   logic              overflow_q, underflow_q;
   logic              wr_acc, rd_acc;

   // Flags come straight off the registered count, so they lag the causing edge by one cycle.
   assign w_full       = (count_q == CNT_FULL);
   assign r_empty      = (count_q == '0);
   assign almost_full  = (count_q >= CNT_AF);
   assign almost_empty = (count_q <= CNT_AE);
   assign wr_acc       = w_en && !w_full;
   assign rd_acc       = r_en && !r_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      r_data_d = r_data_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + CNT_ONE;
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + CNT_ONE;
         r_data_d = mem_rdata;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         r_data_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         r_data_q    <= r_data_d;
         overflow_q  <= w_en && w_full;
         underflow_q <= r_en && r_empty;
      end
   end

   sync_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc && !rst),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (w_data),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (mem_rdata)
   );

   // FWFT exposes the head word directly; standard mode presents the word popped last.
   assign r_data    = (FWFT == MODE_FWFT) ? mem_rdata : r_data_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
